// File: rtl/sik_encoder.sv
// SIK instruction-stream encoder: turns symbolic instructions into 16-bit fetch words,
// inserting a prefix word when the immediate does not fit a sign-extended 12-bit field.
module sik_encoder #(
  parameter logic [15:0] BASE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ext,
  input  logic [3:0]  in_op,
  input  logic [15:0] in_imm,
  input  logic        base_load,
  input  logic [15:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic [15:0] out_addr,
  output logic [15:0] count,
  output logic        err
);

  localparam int unsigned W    = 16;
  localparam int unsigned OPW  = 4;
  localparam int unsigned IMMW = 12;
  localparam int unsigned PFXW = W - IMMW;

  localparam logic [OPW-1:0] OP_PREFIX   = 4'b1111;
  localparam logic [OPW-1:0] NORM_OP_MIN = 4'b0001;
  localparam logic [OPW-1:0] NORM_OP_MAX = 4'b1000;
  localparam logic [OPW-1:0] EXT_OP_MIN  = 4'b0001;
  localparam logic [OPW-1:0] EXT_OP_MAX  = 4'b1100;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [W-1:0] hold_word;
  logic [W-1:0] addr_cnt;

  logic         accept;
  logic         out_hs;
  logic         op_legal;
  logic         need_prefix;
  logic [W-1:0] norm_word;
  logic [W-1:0] ext_word;
  logic [W-1:0] prefix_word;

  logic         load;
  logic [W-1:0] load_word;
  logic         load_hold;
  logic         set_err;
  logic         take_base;

  // Instruction decode and word formatting
  assign norm_word   = {in_op, in_imm[IMMW-1:0]};
  assign ext_word    = {(W-OPW)'(0), in_op};
  assign prefix_word = {OP_PREFIX, (W-OPW-PFXW)'(0), in_imm[W-1:IMMW]};
  assign need_prefix = in_imm[W-1:IMMW] != {PFXW{in_imm[IMMW-1]}};
  assign op_legal    = in_ext ? ((in_op >= EXT_OP_MIN)  && (in_op <= EXT_OP_MAX))
                              : ((in_op >= NORM_OP_MIN) && (in_op <= NORM_OP_MAX));

  assign out_hs   = out_valid && out_ready;
  assign in_ready = (state == IDLE) && !reset && !base_load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath load control
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_word = norm_word;
    load_hold = 1'b0;
    set_err   = 1'b0;
    take_base = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!op_legal) begin
            set_err = 1'b1;
          end else if (in_ext) begin
            load      = 1'b1;
            load_word = ext_word;
          end else if (need_prefix) begin
            load      = 1'b1;
            load_word = prefix_word;
            load_hold = 1'b1;
            state_nxt = HOLD;
          end else begin
            load      = 1'b1;
            load_word = norm_word;
          end
        end else if (base_load && !reset && (!out_valid || out_ready)) begin
          take_base = 1'b1;
        end
      end
      HOLD: begin
        if (out_hs) begin
          load      = 1'b1;
          load_word = hold_word;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, hold word and address counter
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_addr  <= BASE;
      addr_cnt  <= BASE;
      hold_word <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_word  <= load_word;
        out_addr  <= addr_cnt;
        addr_cnt  <= addr_cnt + W'(1);
      end else begin
        if (out_hs) begin
          out_valid <= 1'b0;
        end
        if (take_base) begin
          addr_cnt <= base_addr;
        end
      end
      if (load_hold) begin
        hold_word <= norm_word;
      end
    end
  end

  // Handshake counter and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (out_hs) begin
        count <= count + W'(1);
      end
      if (set_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sik_encoder.sv
// Bench for sik_encoder: directed literal checks plus randomized traffic against a queue-based model.
module tb_sik_encoder;

  localparam logic [15:0] TB_BASE = 16'h0010;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ext;
  logic [3:0]  in_op;
  logic [15:0] in_imm;
  logic        base_load;
  logic [15:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [15:0] out_addr;
  logic [15:0] count;
  logic        err;

  sik_encoder #(.BASE(TB_BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ext    (in_ext),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .base_load (base_load),
    .base_addr (base_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words accepted but not yet taken by the consumer, each with its address
  logic [15:0] mq_word[$];
  logic [15:0] mq_addr[$];
  logic [15:0] m_cnt;
  logic [15:0] m_count;
  logic        m_err;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !reset && !base_load &&
           (mq_word.size() == 0 || (mq_word.size() == 1 && out_ready));
  endfunction

  function automatic bit legal(input bit e, input logic [3:0] op);
    int o = int'(op);
    return e ? (o >= 1 && o <= 12) : (o >= 1 && o <= 8);
  endfunction

  // Immediate needs a prefix when it lies outside the signed 12-bit range
  function automatic bit needs_prefix(input logic [15:0] imm);
    int s = int'($signed(imm));
    return (s < -2048) || (s > 2047);
  endfunction

  task automatic model_reset();
    mq_word.delete();
    mq_addr.delete();
    m_cnt   = TB_BASE;
    m_count = 16'h0000;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs();
    chk("in_ready", 16'(in_ready), 16'(exp_ready()));
    chk("out_valid", 16'(out_valid), 16'(mq_word.size() != 0));
    chk("err", 16'(err), 16'(m_err));
    chk("count", count, m_count);
    if (mq_word.size() != 0) begin
      chk("out_word", out_word, mq_word[0]);
      chk("out_addr", out_addr, mq_addr[0]);
    end
  endtask

  task automatic model_update();
    bit rdy;
    bit hs;
    bit base_ok;
    if (reset) begin
      model_reset();
      return;
    end
    rdy     = exp_ready();
    hs      = (mq_word.size() != 0) && out_ready;
    base_ok = base_load && (mq_word.size() == 0 || (mq_word.size() == 1 && out_ready));
    if (hs) begin
      void'(mq_word.pop_front());
      void'(mq_addr.pop_front());
      m_count = m_count + 16'd1;
    end
    if (in_valid && rdy) begin
      if (!legal(in_ext, in_op)) begin
        m_err = 1'b1;
      end else if (in_ext) begin
        mq_word.push_back({12'h000, in_op});
        mq_addr.push_back(m_cnt);
        m_cnt = m_cnt + 16'd1;
      end else if (needs_prefix(in_imm)) begin
        mq_word.push_back({4'hF, 8'h00, in_imm[15:12]});
        mq_addr.push_back(m_cnt);
        mq_word.push_back({in_op, in_imm[11:0]});
        mq_addr.push_back(m_cnt + 16'd1);
        m_cnt = m_cnt + 16'd2;
      end else begin
        mq_word.push_back({in_op, in_imm[11:0]});
        mq_addr.push_back(m_cnt);
        m_cnt = m_cnt + 16'd1;
      end
    end else if (base_ok) begin
      m_cnt = base_addr;
    end
  endtask

  // One cycle: drive at negedge, compare shortly after, advance the model at posedge
  task automatic step(input bit v, input bit e, input logic [3:0] op, input logic [15:0] imm,
                      input bit bl, input logic [15:0] ba, input bit ordy, input bit rst);
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_ext    = e;
    in_op     = op;
    in_imm    = imm;
    base_load = bl;
    base_addr = ba;
    out_ready = ordy;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, ordy, 1'b0);
  endtask

  function automatic logic [15:0] rand_imm();
    case ($urandom_range(3))
      0:       return 16'($urandom);
      1:       return 16'(2045 + int'($urandom_range(5)));
      2:       return 16'(-2051 + int'($urandom_range(5)));
      default: return 16'($urandom_range(40));
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ext = 1'b0; in_op = 4'h0; in_imm = 16'h0;
    base_load = 1'b0; base_addr = 16'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #2;

    // Reset state
    step(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("rst out_valid", 16'(out_valid), 16'h0000);
    chk("rst out_word", out_word, 16'h0000);
    chk("rst out_addr", out_addr, TB_BASE);
    chk("rst count", count, 16'h0000);
    chk("rst err", 16'(err), 16'h0000);

    // Short push, long push, prefix boundaries
    step(1'b1, 1'b0, 4'b1000, 16'h0005, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("short word", out_word, 16'h8005);
    chk("short addr", out_addr, 16'h0010);
    step(1'b1, 1'b0, 4'b1000, 16'h1234, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("long prefix", out_word, 16'hF001);
    chk("long prefix addr", out_addr, 16'h0011);
    chk("hold in_ready", 16'(in_ready), 16'h0000);
    idle(1'b1);
    chk("long main", out_word, 16'h8234);
    chk("long main addr", out_addr, 16'h0012);
    step(1'b1, 1'b0, 4'b1000, 16'hFFFE, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("imm FFFE", out_word, 16'h8FFE);
    step(1'b1, 1'b0, 4'b1000, 16'h0800, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("imm 0800 prefix", out_word, 16'hF000);
    idle(1'b1);
    chk("imm 0800 main", out_word, 16'h8800);
    step(1'b1, 1'b0, 4'b1000, 16'h07FF, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("imm 07FF", out_word, 16'h87FF);
    chk("imm 07FF addr", out_addr, 16'h0016);
    idle(1'b1);
    chk("drain count", count, 16'd7);

    // Backpressure: add held for three cycles, then ret
    step(1'b1, 1'b1, 4'b0001, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'b1000, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("bp held word", out_word, 16'h0001);
      chk("bp held addr", out_addr, 16'h0017);
    end
    step(1'b1, 1'b1, 4'b1000, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("bp ret word", out_word, 16'h0008);
    chk("bp ret addr", out_addr, 16'h0018);
    idle(1'b1);
    chk("bp count", count, 16'd9);

    // Illegal inputs
    step(1'b1, 1'b0, 4'b1111, 16'h0003, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("illegal norm err", 16'(err), 16'h0001);
    chk("illegal norm valid", 16'(out_valid), 16'h0000);
    step(1'b1, 1'b1, 4'b1101, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("illegal ext err", 16'(err), 16'h0001);
    chk("illegal ext valid", 16'(out_valid), 16'h0000);

    // Reset while holding the second word of a long-form instruction
    step(1'b1, 1'b0, 4'b1000, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("hold rst err", 16'(err), 16'h0000);
    chk("hold rst valid", 16'(out_valid), 16'h0000);
    chk("hold rst addr", out_addr, TB_BASE);

    // Address wrap after base load
    step(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'b0001, 16'h2000, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("wrap prefix", out_word, 16'hF002);
    chk("wrap prefix addr", out_addr, 16'hFFFF);
    idle(1'b1);
    chk("wrap main", out_word, 16'h1000);
    chk("wrap main addr", out_addr, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(9) < 7, $urandom_range(9) < 3, 4'($urandom_range(15)), rand_imm(),
           $urandom_range(15) == 0, 16'($urandom), $urandom_range(9) < 7,
           $urandom_range(299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sik_encoder.md
# sik_encoder

Instruction-stream encoder for the SIK stack ISA, the write-side counterpart of the pipelined core's fetch/decode path. It accepts one symbolic instruction per handshake (opcode, extended flag, 16-bit immediate) and emits the exact 16-bit instruction words the core fetches. A `pre` prefix word is inserted automatically when the immediate does not fit a sign-extended 12-bit field. It sits between the test/loader logic and the instruction memory image, and supplies a word address with every emitted word.

## Interface
- `BASE`, default 16'h0000: reset value of the word-address counter.
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`.
- `in_valid`  in  1  an instruction is presented.
- `in_ready`  out  1  encoder accepts the instruction this cycle.
- `in_ext`  in  1  1 = extended (no-argument) op; 0 = normal op.
- `in_op`  in  4  normal opcode (get..push) or extended opcode (add..test).
- `in_imm`  in  16  immediate for normal ops; ignored when `in_ext`=1.
- `base_load`  in  1  load `base_addr` into the address counter.
- `base_addr`  in  16  new word address.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  consumer takes `out_word` this cycle.
- `out_word`  out  16  encoded instruction word.
- `out_addr`  out  16  word address of `out_word`.
- `count`  out  16  words emitted since reset; wraps.
- `err`  out  1  sticky illegal-instruction flag.

## Operation
- Encodings:
  - Normal: {op[3:0], imm12}.
  - Extended: {4'b0000, 8'h00, ext[3:0]}.
  - Prefix: {4'b1111, 8'h00, imm[15:12]}.
- Prefix rule: a prefix is needed iff imm[15:12] != {4{imm[11]}}.
  - Needed: emit the prefix, then {op, imm[11:0]}.
  - Not needed: emit the single word.
- Legal normal ops: 4'b0001..4'b1000. Opcode 4'b1111 is illegal as input; the encoder generates it internally.
- Legal extended ops: 4'b0001..4'b1100.
- Illegal input:
  - The handshake still completes.
  - Nothing is emitted.
  - `err` sets and stays 1 until reset.
- FSM, 2 states:
  - IDLE:
    - `in_ready` = !reset && !base_load && (!out_valid || out_ready).
    - Accepting a short-form or extended instruction loads the output register and stays in IDLE.
    - Accepting a long-form instruction loads the prefix into the output register and the main word into a hold register, then goes to HOLD.
  - HOLD:
    - `in_ready`=0.
    - When `out_valid && out_ready`, load the hold word into the output register and return to IDLE.
- Output register:
  - `out_valid` rises when a word is loaded.
  - If no new word is loaded, `out_valid` clears on `out_valid && out_ready`.
  - `out_word` and `out_addr` are stable while `out_valid && !out_ready`.
- Address counter:
  - The counter value is captured into `out_addr` when a word is loaded.
  - The counter increments by 1 per loaded word and wraps 16'hFFFF to 16'h0000.
  - `base_load` takes effect only in IDLE with `out_valid`=0, or in IDLE when the current word is handshaking that same cycle. Otherwise it is ignored.
- `count`: increments on each output handshake (`out_valid && out_ready`); wraps.

## Timing
- Reset values:
  - `out_valid`=0, `out_word`=16'h0000, `out_addr`=`BASE`, address counter=`BASE`.
  - `count`=0, `err`=0, state=IDLE.
  - `in_ready`=0 while `reset` is high.
- Reset asserted in HOLD discards both the pending prefix and the hold word.
- Latency: word valid on the cycle after the accept edge.
- Throughput with `out_ready` held 1:
  - 1 instruction/cycle for short form.
  - 2 cycles per long-form instruction (`in_ready` low exactly one cycle).
- Simultaneous output handshake and new accept in IDLE: the new word replaces the old one with no bubble; `count` increments.
- An illegal accept does not touch `out_valid`; a word already pending continues unchanged.

## Test plan
- Short push: push (4'b1000), imm 16'h0005 → `out_word` 16'h8005, `out_addr` 0, `in_ready` stays 1.
- Long push, imm 16'h1234 → 16'hF001 at addr 0, then 16'h8234 at addr 1; `in_ready`=0 for one cycle.
- Prefix boundaries:
  - imm 16'hFFFE → single word 16'h8FFE.
  - imm 16'h0800 → 16'hF000, then 16'h8800.
  - imm 16'h07FF → single word 16'h87FF.
- Backpressure: ext add (4'b0001), then ext ret (4'b1000), with `out_ready` low 3 cycles → 16'h0001 held stable, then 16'h0008; no loss; `count`=2.
- Illegal inputs:
  - Normal op 4'b1111 → `err`=1, no word emitted.
  - Ext op 4'b1101 → `err` stays 1.
  - `reset` pulsed mid-HOLD → `err`=0, `out_valid`=0, `out_addr`=`BASE`.
- Address: `base_load` 16'hFFFF, then a long-form get (4'b0001) with imm 16'h2000 → 16'hF002 at 16'hFFFF, then 16'h1000 at 16'h0000.
